// File: rtl/fxdiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fxdiv_pkg : state encoding and sizing helpers for the sequential divider
// Rev 1.0
// ---------------------------------------------------------------------------
package fxdiv_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } fxdiv_state_e;

   function automatic int unsigned fxdiv_iters(input int unsigned width, input int unsigned frac);
      return width + frac;
   endfunction

   function automatic int unsigned fxdiv_cnt_width(input int unsigned width, input int unsigned frac);
      return $clog2(width + frac);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fxdiv_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fxdiv_step : one combinational restoring-division step
// Rev 1.0
// ---------------------------------------------------------------------------
module fxdiv_step
   import fxdiv_pkg::*;
#(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   // rem_in is always below the divisor, so the shifted value fits WIDTH+1
   // bits and the extra top bit of diff acts as the borrow/sign flag.
   always_comb begin
      shifted = {rem_in, bit_in};
      diff    = shifted - {2'b00, divisor};
      q_bit   = ~diff[WIDTH+1];
      rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
   end

endmodule
`default_nettype wire

// File: rtl/fixed_point_divider_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fixed_point_divider_seq : handshaked unsigned Q = (a << FRAC) / b divider
// Rev 1.0
// ---------------------------------------------------------------------------
module fixed_point_divider_seq
   import fxdiv_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int FRAC  = 4,
   parameter int ROUND = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rem,
   output logic             ov,
   output logic             dvz
);

   localparam int              N        = int'(fxdiv_iters(WIDTH, FRAC));
   localparam int              CW       = int'(fxdiv_cnt_width(WIDTH, FRAC));
   localparam logic [WIDTH-1:0] ONES    = '1;
   localparam logic [CW-1:0]   CNT_LOAD = CW'(N - 1);

   fxdiv_state_e     state_q, state_d;
   logic [N-1:0]     dvd_q, dvd_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH:0]   prem_q, prem_d;
   // Only N-1 quotient bits need storing; the last one is produced on the finalising step.
   logic [N-2:0]     raw_q, raw_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d, ov_q, ov_d, dvz_q, dvz_d;
   logic [WIDTH-1:0] q_q, q_d, rem_q, rem_d;

   logic [WIDTH:0]   step_rem;
   logic             step_bit;
   logic [N-1:0]     raw_next;
   logic             raw_hi;
   logic             round_up;
   logic [WIDTH:0]   q_inc;

   fxdiv_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (prem_q),
      .bit_in  (dvd_q[N-1]),
      .divisor (div_q),
      .rem_out (step_rem),
      .q_bit   (step_bit)
   );

   assign raw_next = {raw_q, step_bit};

   generate
      if (FRAC > 0) begin : g_ov_frac
         assign raw_hi = |raw_next[N-1:WIDTH];
      end else begin : g_ov_none
         assign raw_hi = 1'b0;
      end
   endgenerate

   assign round_up = (ROUND != 0) && ({step_rem[WIDTH-1:0], 1'b0} >= {1'b0, div_q});
   assign q_inc    = {1'b0, raw_next[WIDTH-1:0]} + {{WIDTH{1'b0}}, round_up};

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (b == '0) ? S_DONE : S_RUN;
         S_RUN:   if (cnt_q == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dvd_d  = dvd_q;
      div_d  = div_q;
      prem_d = prem_q;
      raw_d  = raw_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      q_d    = q_q;
      rem_d  = rem_q;
      ov_d   = ov_q;
      dvz_d  = dvz_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               dvd_d  = N'(a) << FRAC;
               div_d  = b;
               prem_d = '0;
               raw_d  = '0;
               cnt_d  = CNT_LOAD;
               q_d    = '0;
               rem_d  = '0;
               ov_d   = 1'b0;
               dvz_d  = 1'b0;
               if (b == '0) begin
                  q_d    = ONES;
                  dvz_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  busy_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            dvd_d  = dvd_q << 1;
            prem_d = step_rem;
            raw_d  = raw_next[N-2:0];
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               rem_d  = step_rem[WIDTH-1:0];
               ov_d   = raw_hi | q_inc[WIDTH];
               q_d    = (raw_hi | q_inc[WIDTH]) ? ONES : q_inc[WIDTH-1:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_q  <= '0;
         div_q  <= '0;
         prem_q <= '0;
         raw_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         q_q    <= '0;
         rem_q  <= '0;
         ov_q   <= 1'b0;
         dvz_q  <= 1'b0;
      end else begin
         dvd_q  <= dvd_d;
         div_q  <= div_d;
         prem_q <= prem_d;
         raw_q  <= raw_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
         q_q    <= q_d;
         rem_q  <= rem_d;
         ov_q   <= ov_d;
         dvz_q  <= dvz_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign q    = q_q;
   assign rem  = rem_q;
   assign ov   = ov_q;
   assign dvz  = dvz_q;

endmodule
`default_nettype wire
